// File: rtl/uart_reg_decoder_if.sv
// Byte stream and register-bank signals between the UART datapath and the command decoder.
// The master side feeds received bytes and transmitter status; the slave side is the decoder.
interface uart_reg_decoder_if;
  logic         uart_rx_valid;
  logic [7:0]   uart_rx_data;
  logic         uart_tx_busy;
  logic         uart_tx_en;
  logic [7:0]   uart_tx_data;
  logic [127:0] regs_out;
  logic         wr_strobe;
  logic [3:0]   wr_addr;
  logic         cmd_error;

  modport master (
    output uart_rx_valid, uart_rx_data, uart_tx_busy,
    input  uart_tx_en, uart_tx_data, regs_out, wr_strobe, wr_addr, cmd_error
  );

  modport slave (
    input  uart_rx_valid, uart_rx_data, uart_tx_busy,
    output uart_tx_en, uart_tx_data, regs_out, wr_strobe, wr_addr, cmd_error
  );
endinterface

// File: rtl/uart_reg_decoder.sv
// UART byte command decoder: write = command + value byte, read = command byte answered on TX.
// Exposes a 16 x 8-bit register bank; register 15 is a read-only ID constant.
module uart_reg_decoder #(
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned BIT_RATE      = 11520,
  parameter int unsigned TIMEOUT_BYTES = 4,
  parameter logic [7:0]  ID_VALUE      = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  uart_reg_decoder_if.slave bus
);

  localparam longint TO_CYC_L = (longint'(CLK_HZ) * 64'sd10 * longint'(TIMEOUT_BYTES)) / longint'(BIT_RATE);
  localparam logic [31:0] TO_CYC = (TO_CYC_L < 1) ? 32'd1 : 32'(TO_CYC_L);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VALUE,
    ST_TX_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  addr_q, addr_d;
  logic        malformed_q, malformed_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  reply_q, reply_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic        cmd_error_q, cmd_error_d;
  logic        wr_en;

  logic [7:0]   regs_q [15];
  logic [127:0] bank;
  logic [3:0]   rx_addr;
  logic         rx_is_write;
  logic         rx_malformed;
  logic [7:0]   rx_rd_val;

  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          regs_q[gi] <= 8'h00;
        end else if (wr_en && (addr_q == 4'(gi))) begin
          regs_q[gi] <= bus.uart_rx_data;
        end
      end
      assign bank[8*gi +: 8] = regs_q[gi];
    end
  endgenerate
  assign bank[127:120] = ID_VALUE;

  assign rx_addr      = bus.uart_rx_data[3:0];
  assign rx_is_write  = bus.uart_rx_data[7];
  assign rx_malformed = |bus.uart_rx_data[6:4];
  assign rx_rd_val    = bank[{rx_addr, 3'b000} +: 8];

  // Reads bypass TX_WAIT when the transmitter is already free, giving one-cycle reply latency.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    malformed_d = malformed_q;
    cnt_d       = cnt_q;
    reply_d     = reply_q;
    tx_en_d     = 1'b0;
    tx_data_d   = tx_data_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    cmd_error_d = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 32'd0;
        if (bus.uart_rx_valid) begin
          if (rx_is_write) begin
            state_d     = ST_WAIT_VALUE;
            addr_d      = rx_addr;
            malformed_d = rx_malformed;
          end else if (rx_malformed) begin
            cmd_error_d = 1'b1;
          end else if (!bus.uart_tx_busy) begin
            tx_en_d   = 1'b1;
            tx_data_d = rx_rd_val;
          end else begin
            reply_d = rx_rd_val;
            state_d = ST_TX_WAIT;
          end
        end
      end

      ST_WAIT_VALUE: begin
        if (bus.uart_rx_valid) begin
          state_d = ST_IDLE;
          cnt_d   = 32'd0;
          if (malformed_q) begin
            cmd_error_d = 1'b1;
          end else if (addr_q != 4'hF) begin
            wr_en       = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
          end
        end else if (cnt_q == TO_CYC - 32'd1) begin
          cmd_error_d = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_TX_WAIT: begin
        if (bus.uart_rx_valid) begin
          cmd_error_d = 1'b1;
        end
        if (!bus.uart_tx_busy) begin
          tx_en_d   = 1'b1;
          tx_data_d = reply_q;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= 4'h0;
      malformed_q <= 1'b0;
      cnt_q       <= 32'd0;
      reply_q     <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_data_q   <= 8'h00;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'h0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      malformed_q <= malformed_d;
      cnt_q       <= cnt_d;
      reply_q     <= reply_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  assign bus.uart_tx_en   = tx_en_q;
  assign bus.uart_tx_data = tx_data_q;
  assign bus.regs_out     = bank;
  assign bus.wr_strobe    = wr_strobe_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.cmd_error    = cmd_error_q;

endmodule

// File: tb/tb_uart_reg_decoder.sv
// Self-checking bench for uart_reg_decoder: fixed vector table, hand-written corner sequences,
// and randomized byte traffic compared against a transaction-level reference model.
module tb_uart_reg_decoder;

  localparam int unsigned CLK_HZ        = 115200;
  localparam int unsigned BIT_RATE      = 11520;
  localparam int unsigned TIMEOUT_BYTES = 4;
  localparam logic [7:0]  ID_VALUE      = 8'hA5;
  localparam int          TO_CYC        = CLK_HZ * 10 * TIMEOUT_BYTES / BIT_RATE;

  logic clk;
  logic reset;

  uart_reg_decoder_if bus();

  uart_reg_decoder #(
    .CLK_HZ(CLK_HZ),
    .BIT_RATE(BIT_RATE),
    .TIMEOUT_BYTES(TIMEOUT_BYTES),
    .ID_VALUE(ID_VALUE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_en   = 0;
  int cnt_err  = 0;
  int cnt_wr   = 0;

  // Reference model: a command is either absent, a write awaiting its value, or a queued reply.
  logic [7:0] m_mem [16];
  bit         m_wait_value;
  bit         m_reply_pending;
  logic [7:0] m_cmd;
  logic [7:0] m_reply;
  int         m_elapsed;
  logic [7:0] m_tx_data;
  logic [3:0] m_wr_addr;
  bit         e_en, e_err, e_wr;

  function automatic logic [7:0] m_read(input logic [3:0] a);
    return (a == 4'hF) ? ID_VALUE : m_mem[a];
  endfunction

  function automatic logic [127:0] m_bank();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = m_read(4'(i));
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_wait_value    = 0;
    m_reply_pending = 0;
    m_cmd           = 8'h00;
    m_reply         = 8'h00;
    m_elapsed       = 0;
    m_tx_data       = 8'h00;
    m_wr_addr       = 4'h0;
    e_en = 0; e_err = 0; e_wr = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit busy);
    e_en = 0; e_err = 0; e_wr = 0;
    if (m_reply_pending) begin
      if (v) e_err = 1;
      if (!busy) begin
        e_en = 1;
        m_tx_data = m_reply;
        m_reply_pending = 0;
      end
    end else if (m_wait_value) begin
      if (v) begin
        m_wait_value = 0;
        if (m_cmd[6:4] != 3'b000) e_err = 1;
        else if (m_cmd[3:0] != 4'hF) begin
          m_mem[m_cmd[3:0]] = d;
          m_wr_addr = m_cmd[3:0];
          e_wr = 1;
        end
      end else begin
        m_elapsed++;
        if (m_elapsed == TO_CYC) begin
          e_err = 1;
          m_wait_value = 0;
        end
      end
    end else if (v) begin
      if (d[7]) begin
        m_wait_value = 1;
        m_cmd = d;
        m_elapsed = 0;
      end else if (d[6:4] != 3'b000) begin
        e_err = 1;
      end else if (!busy) begin
        e_en = 1;
        m_tx_data = m_read(d[3:0]);
      end else begin
        m_reply = m_read(d[3:0]);
        m_reply_pending = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("tx_en", 128'(bus.uart_tx_en), 128'(e_en));
    chk("tx_data", 128'(bus.uart_tx_data), 128'(m_tx_data));
    chk("cmd_error", 128'(bus.cmd_error), 128'(e_err));
    chk("wr_strobe", 128'(bus.wr_strobe), 128'(e_wr));
    chk("wr_addr", 128'(bus.wr_addr), 128'(m_wr_addr));
    chk("regs_out", bus.regs_out, m_bank());
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit busy);
    bus.uart_rx_valid = v;
    bus.uart_rx_data  = d;
    bus.uart_tx_busy  = busy;
    @(posedge clk);
    model_step(v, d, busy);
    #1;
    bus.uart_rx_valid = 1'b0;
    if (bus.uart_tx_en) cnt_en++;
    if (bus.cmd_error) cnt_err++;
    if (bus.wr_strobe) cnt_wr++;
    compare_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.uart_rx_valid = 1'b0;
    bus.uart_tx_busy  = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    compare_model();
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         busy;
    bit         en;
    logic [7:0] data;
    bit         err;
    bit         wr;
    logic [3:0] waddr;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int err0, en0, wr0, err_at;
    logic [7:0] rb;
    bit busy_r;

    reset = 1'b1;
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_data  = 8'h00;
    bus.uart_tx_busy  = 1'b0;

    tbl[0]  = '{1'b1, 8'h83, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0};
    tbl[1]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'h3};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h3};
    tbl[3]  = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 4'h3};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 4'h3};
    tbl[5]  = '{1'b1, 8'h0F, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 4'h3};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 4'h3};
    tbl[7]  = '{1'b1, 8'hF2, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 4'h3};
    tbl[8]  = '{1'b1, 8'h77, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 4'h3};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 4'h3};
    tbl[10] = '{1'b1, 8'h8F, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 4'h3};
    tbl[11] = '{1'b1, 8'h12, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 4'h3};
    tbl[12] = '{1'b1, 8'h0F, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 4'h3};
    tbl[13] = '{1'b1, 8'h05, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 4'h3};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 4'h3};
    tbl[15] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 4'h3};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 4'h3};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h3};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h3};

    repeat (2) @(posedge clk);
    do_reset();
    chk("reset_regs", bus.regs_out, {ID_VALUE, 120'h0});
    chk("reset_tx_data", 128'(bus.uart_tx_data), 128'h00);
    chk("reset_pulses", 128'({bus.uart_tx_en, bus.wr_strobe, bus.cmd_error}), 128'h0);
    $display("reset: regs_out=%h", bus.regs_out);

    // Vector table
    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].busy);
      chk("vec_tx_en", 128'(bus.uart_tx_en), 128'(tbl[i].en));
      chk("vec_tx_data", 128'(bus.uart_tx_data), 128'(tbl[i].data));
      chk("vec_cmd_error", 128'(bus.cmd_error), 128'(tbl[i].err));
      chk("vec_wr_strobe", 128'(bus.wr_strobe), 128'(tbl[i].wr));
      chk("vec_wr_addr", 128'(bus.wr_addr), 128'(tbl[i].waddr));
      $display("vec %0d: rx_v=%0d rx=%h busy=%0d -> en=%0d data=%h err=%0d wr=%0d waddr=%0d",
               i, tbl[i].v, tbl[i].d, tbl[i].busy, bus.uart_tx_en, bus.uart_tx_data,
               bus.cmd_error, bus.wr_strobe, bus.wr_addr);
    end
    chk("vec_bank", bus.regs_out, {8'hA5, 88'h0, 8'h3C, 24'h0});

    // Reply held off by a long busy period, with a dropped byte meanwhile
    do_reset();
    en0 = cnt_en; err0 = cnt_err;
    cycle(1'b1, 8'h05, 1'b1);
    for (int i = 1; i < 100; i++) begin
      if (i == 50) cycle(1'b1, 8'h11, 1'b1);
      else cycle(1'b0, 8'h00, 1'b1);
    end
    chk("busy_no_en", 128'(cnt_en - en0), 128'd0);
    chk("busy_one_err", 128'(cnt_err - err0), 128'd1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("busy_release_en", 128'(bus.uart_tx_en), 128'd1);
    chk("busy_release_data", 128'(bus.uart_tx_data), 128'h00);
    $display("busy seq: released en=%0d data=%h", bus.uart_tx_en, bus.uart_tx_data);

    // Inter-byte timeout
    do_reset();
    err0 = cnt_err; err_at = -1;
    cycle(1'b1, 8'h81, 1'b0);
    for (int i = 1; i <= TO_CYC + 5; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (bus.cmd_error && err_at < 0) err_at = i;
    end
    chk("timeout_err_count", 128'(cnt_err - err0), 128'd1);
    chk("timeout_err_cycle", 128'(err_at), 128'(TO_CYC));
    cycle(1'b1, 8'h02, 1'b0);
    chk("timeout_read_en", 128'(bus.uart_tx_en), 128'd1);
    chk("timeout_read_data", 128'(bus.uart_tx_data), 128'h00);
    chk("timeout_reg1", 128'(bus.regs_out[15:8]), 128'h00);
    $display("timeout seq: error after %0d cycles", err_at);

    // Value byte landing on the timeout cycle wins
    err0 = cnt_err;
    cycle(1'b1, 8'h86, 1'b0);
    for (int i = 1; i < TO_CYC; i++) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0);
    chk("edge_wr", 128'(bus.wr_strobe), 128'd1);
    chk("edge_reg6", 128'(bus.regs_out[55:48]), 128'h5A);
    cycle(1'b0, 8'h00, 1'b0);
    chk("edge_no_err", 128'(cnt_err - err0), 128'd0);
    $display("edge seq: reg6=%h", bus.regs_out[55:48]);

    // Reset in the middle of a write
    cycle(1'b1, 8'h84, 1'b0);
    do_reset();
    en0 = cnt_en; wr0 = cnt_wr;
    cycle(1'b1, 8'h55, 1'b0);
    chk("rst_mid_err", 128'(bus.cmd_error), 128'd1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("rst_mid_no_en", 128'(cnt_en - en0), 128'd0);
    chk("rst_mid_no_wr", 128'(cnt_wr - wr0), 128'd0);
    chk("rst_mid_reg4", 128'(bus.regs_out[39:32]), 128'h00);
    $display("reset-mid-write seq: reg4=%h", bus.regs_out[39:32]);

    // Reset while a reply is pending
    cycle(1'b1, 8'h03, 1'b1);
    do_reset();
    en0 = cnt_en; err0 = cnt_err;
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    chk("rst_txwait_no_en", 128'(cnt_en - en0), 128'd0);
    chk("rst_txwait_no_err", 128'(cnt_err - err0), 128'd0);
    $display("reset-mid-reply seq: en pulses=%0d", cnt_en - en0);

    // Randomized traffic against the model
    do_reset();
    busy_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int k;
      bit v;
      if ($urandom_range(0, 9) == 0) busy_r = ~busy_r;
      v = ($urandom_range(0, 9) < 3);
      k = $urandom_range(0, 9);
      if (k < 4)      rb = {4'b1000, 4'($urandom_range(0, 15))};
      else if (k < 7) rb = {4'b0000, 4'($urandom_range(0, 15))};
      else            rb = 8'($urandom);
      cycle(v, rb, busy_r);
    end
    $display("random: %0d tx pulses, %0d writes, %0d errors", cnt_en, cnt_wr, cnt_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
